// File: rtl/spu_rf_pkg.sv
// Shared types and helpers for the multi-port SPU register file.
package spu_rf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2
  } rf_state_e;

  localparam int unsigned RF_WIDTH  = 128;
  localparam int unsigned RF_NUM_RD = 6;
  localparam int unsigned BE_W      = RF_WIDTH / 8;

  // Slice k of a flattened read-data bus at the default geometry; slice 0 is leftmost.
  function automatic logic [0:RF_WIDTH-1] get_slice(input logic [0:RF_NUM_RD*RF_WIDTH-1] vec,
                                                    input int unsigned k);
    return vec[k*RF_WIDTH +: RF_WIDTH];
  endfunction

endpackage

// File: rtl/spu_regfile_mp_if.sv
// Write, read, clear and preload signals of the SPU register file.
interface spu_regfile_mp_if #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned NUM_RD = 6
);
  localparam int unsigned BW = WIDTH / 8;

  logic [0:NUM_WR-1]       wr_en;
  logic [0:NUM_WR*AW-1]    wr_addr;
  logic [0:NUM_WR*WIDTH-1] wr_data;
  logic [0:NUM_WR*BW-1]    wr_be;
  logic [0:NUM_RD*AW-1]    rd_addr;
  logic [0:NUM_RD*WIDTH-1] rd_data;
  logic                    clr_req;
  logic                    ld_start;
  logic [0:AW-1]           ld_base;
  logic                    ld_valid;
  logic [0:WIDTH-1]        ld_data;
  logic                    ld_last;
  logic                    ld_ready;
  logic                    busy;
  logic                    done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_addr,
    output clr_req, ld_start, ld_base, ld_valid, ld_data, ld_last,
    input  rd_data, ld_ready, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_addr,
    input  clr_req, ld_start, ld_base, ld_valid, ld_data, ld_last,
    output rd_data, ld_ready, busy, done
  );

endinterface

// File: rtl/spu_rf_bypass.sv
// One read port: byte-wise forwarding of same-cycle writes over the stored entry.
module spu_rf_bypass
  import spu_rf_pkg::*;
#(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned AW     = 7,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                          byp_en_i,
  input  logic [0:NUM_WR-1]             wr_act_i,
  input  logic [0:NUM_WR*AW-1]          wr_addr_i,
  input  logic [0:NUM_WR*WIDTH-1]       wr_data_i,
  input  logic [0:NUM_WR*(WIDTH/8)-1]   wr_be_i,
  input  logic [0:AW-1]                 rd_addr_i,
  input  logic [0:WIDTH-1]              arr_data_i,
  output logic [0:WIDTH-1]              rd_data_o
);

  localparam int unsigned BW = WIDTH / 8;

  // Walk ports from highest to lowest so the lowest-index match is applied last.
  always_comb begin
    rd_data_o = arr_data_i;
    if (byp_en_i) begin
      for (int b = 0; b < BW; b++) begin
        for (int k = NUM_WR - 1; k >= 0; k--) begin
          if (wr_act_i[k] && wr_be_i[k*BW+b] && (wr_addr_i[k*AW +: AW] == rd_addr_i)) begin
            rd_data_o[b*8 +: 8] = wr_data_i[k*WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/spu_regfile_mp.sv
// Parametrised multi-port SPU register file with byte enables, bulk clear and preload stream.
module spu_regfile_mp
  import spu_rf_pkg::*;
#(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned NUM_RD = 6
) (
  input logic             clk,
  input logic             rst,
  spu_regfile_mp_if.slave bus
);

  localparam int unsigned BW       = WIDTH / 8;
  localparam logic [AW:0] DepthLim = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d, ptr_nxt;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [0:WIDTH-1]  mem_q [DEPTH];
  logic [0:WIDTH-1]  mem_d [DEPTH];

  logic [AW-1:0]     waddr  [NUM_WR];
  logic [0:NUM_WR-1] wr_act;
  logic              idle;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DepthLim;
  endfunction

  assign idle = (state_q == IDLE);

  // Writes only land while idle; out-of-range addresses are dropped here.
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign waddr[k]  = bus.wr_addr[k*AW +: AW];
    assign wr_act[k] = bus.wr_en[k] && idle && in_range(waddr[k]);
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [AW-1:0]    raddr;
    logic [0:WIDTH-1] arr_data;
    logic [0:WIDTH-1] port_data;

    assign raddr    = bus.rd_addr[r*AW +: AW];
    assign arr_data = in_range(raddr) ? mem_q[raddr] : '0;

    spu_rf_bypass #(
      .WIDTH  (WIDTH),
      .AW     (AW),
      .NUM_WR (NUM_WR)
    ) u_bypass (
      .byp_en_i   (idle),
      .wr_act_i   (wr_act),
      .wr_addr_i  (bus.wr_addr),
      .wr_data_i  (bus.wr_data),
      .wr_be_i    (bus.wr_be),
      .rd_addr_i  (raddr),
      .arr_data_i (arr_data),
      .rd_data_o  (port_data)
    );

    assign bus.rd_data[r*WIDTH +: WIDTH] = port_data;
  end

  assign ptr_nxt = (ptr_q == LastIdx) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (bus.ld_start) begin
          state_d = LOAD;
          ptr_d   = bus.ld_base;
        end
      end
      CLEAR: begin
        ptr_d = ptr_nxt;
        if (ptr_q == LastIdx) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      LOAD: begin
        if (bus.ld_valid) begin
          ptr_d = ptr_nxt;
          if (bus.ld_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = NUM_WR - 1; k >= 0; k--) begin
      if (wr_act[k]) begin
        for (int b = 0; b < BW; b++) begin
          if (bus.wr_be[k*BW+b]) begin
            mem_d[waddr[k]][b*8 +: 8] = bus.wr_data[k*WIDTH + b*8 +: 8];
          end
        end
      end
    end
    if (state_q == CLEAR) begin
      mem_d[ptr_q] = '0;
    end else if (state_q == LOAD && bus.ld_valid) begin
      mem_d[ptr_q] = bus.ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ld_ready = (state_q == LOAD);

endmodule

// File: tb/tb_spu_regfile_mp.sv
// Directed bench for spu_regfile_mp: forwarding, byte merge, bulk clear, preload, reset abort.
module tb_spu_regfile_mp;
  import spu_rf_pkg::*;

  localparam int unsigned W  = 128;
  localparam int unsigned D  = 128;
  localparam int unsigned A  = 7;
  localparam int unsigned NW = 2;
  localparam int unsigned NR = 6;
  localparam int unsigned BW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spu_regfile_mp_if #(.WIDTH(W), .DEPTH(D), .AW(A), .NUM_WR(NW), .NUM_RD(NR)) bus ();

  spu_regfile_mp #(.WIDTH(W), .DEPTH(D), .AW(A), .NUM_WR(NW), .NUM_RD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_be    = '0;
    bus.rd_addr  = '0;
    bus.clr_req  = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_base  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic set_wr(input int k, input logic [6:0] addr, input logic [127:0] data,
                        input logic [15:0] be);
    bus.wr_en[k]              = 1'b1;
    bus.wr_addr[k*A +: A]     = addr;
    bus.wr_data[k*W +: W]     = data;
    bus.wr_be[k*BW +: BW]     = be;
  endtask

  task automatic set_rd(input int r, input logic [6:0] addr);
    bus.rd_addr[r*A +: A] = addr;
  endtask

  function automatic logic [127:0] rd(input int r);
    return get_slice(bus.rd_data, r);
  endfunction

  task automatic beat(input logic [127:0] data, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = data;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int addrs [6];
    logic [127:0] dv [4];
    int busy_cnt, done_cnt, done_cyc;

    addrs = '{0, 5, 17, 64, 100, 127};
    dv[0] = 128'h0123456789abcdef_fedcba9876543210;
    dv[1] = 128'hdeadbeefcafef00d_0badc0de12345678;
    dv[2] = 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    dv[3] = 128'h00000001_00000002_00000003_00000004;

    clear_inputs();
    rst = 1'b1;
    #12;
    set_rd(0, 7'd5);
    #1;
    check_val("rst_rd", rd(0), '0);
    rst = 1'b0;
    tick();

    // 1: reset state on all read ports
    for (int r = 0; r < 6; r++) set_rd(r, 7'(addrs[r]));
    #1;
    for (int r = 0; r < 6; r++) check_val($sformatf("t1_rd%0d", r), rd(r), '0);
    check_val("t1_busy", 128'(bus.busy), '0);
    check_val("t1_done", 128'(bus.done), '0);
    check_val("t1_ready", 128'(bus.ld_ready), '0);

    // 2: forwarding, port 0 wins over port 1
    set_wr(0, 7'd10, {16{8'hAA}}, 16'hFFFF);
    set_wr(1, 7'd10, {16{8'h55}}, 16'hFFFF);
    set_rd(0, 7'd10);
    set_rd(1, 7'd11);
    #1;
    check_val("t2_fwd", rd(0), {16{8'hAA}});
    check_val("t2_other", rd(1), '0);
    tick();
    clear_inputs();
    set_rd(0, 7'd10);
    #1;
    check_val("t2_array", rd(0), {16{8'hAA}});

    // 3: byte-wise merge across ports
    set_wr(0, 7'd3, {16{8'h11}}, 16'hF000);
    set_wr(1, 7'd3, {16{8'h22}}, 16'hFF00);
    set_rd(0, 7'd3);
    #1;
    check_val("t3_fwd", rd(0), 128'h11111111_22222222_00000000_00000000);
    tick();
    clear_inputs();
    set_rd(0, 7'd3);
    #1;
    check_val("t3_array", rd(0), 128'h11111111_22222222_00000000_00000000);
    set_wr(0, 7'd3, {16{8'hFF}}, 16'h0000);
    set_rd(0, 7'd3);
    #1;
    check_val("t3_zero_be_fwd", rd(0), 128'h11111111_22222222_00000000_00000000);
    tick();
    clear_inputs();
    set_rd(0, 7'd3);
    #1;
    check_val("t3_zero_be", rd(0), 128'h11111111_22222222_00000000_00000000);

    // 4: fill, then bulk clear with writes attempted throughout
    for (int a = 0; a < 128; a += 2) begin
      set_wr(0, 7'(a), {16{8'(a + 1)}}, 16'hFFFF);
      set_wr(1, 7'(a + 1), {16{8'(a + 2)}}, 16'hFFFF);
      tick();
    end
    clear_inputs();
    set_rd(0, 7'd5);
    set_rd(1, 7'd127);
    #1;
    check_val("t4_fill5", rd(0), {16{8'h06}});
    check_val("t4_fill127", rd(1), {16{8'h80}});
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    set_wr(0, 7'd5, {16{8'hFF}}, 16'hFFFF);
    set_rd(0, 7'd5);
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 20) check_val("t4_nobyp", rd(0), '0);
      if (c == 120) bus.wr_en = '0;
      if (!bus.busy) break;
      tick();
    end
    check_val("t4_busy_cyc", 128'(busy_cnt), 128'd128);
    check_val("t4_done_cnt", 128'(done_cnt), 128'd1);
    check_val("t4_done_cyc", 128'(done_cyc), 128'd128);
    tick();
    check_val("t4_done_pulse", 128'(bus.done), '0);
    clear_inputs();
    for (int a = 0; a < 128; a++) begin
      set_rd(0, 7'(a));
      #1;
      check_val($sformatf("t4_clr%0d", a), rd(0), '0);
    end

    // 5: preload with wrap and stalls
    tick();
    bus.ld_base  = 7'd126;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    check_val("t5_busy", 128'(bus.busy), 128'd1);
    check_val("t5_ready", 128'(bus.ld_ready), 128'd1);
    beat(dv[0], 1'b0);
    set_rd(0, 7'd126);
    #1;
    check_val("t5_vis", rd(0), dv[0]);
    check_val("t5_done0", 128'(bus.done), '0);
    tick();
    check_val("t5_stall_ready", 128'(bus.ld_ready), 128'd1);
    beat(dv[1], 1'b0);
    beat(dv[2], 1'b0);
    tick();
    tick();
    beat(dv[3], 1'b1);
    check_val("t5_done", 128'(bus.done), 128'd1);
    check_val("t5_busy_fall", 128'(bus.busy), '0);
    check_val("t5_ready_fall", 128'(bus.ld_ready), '0);
    tick();
    check_val("t5_done_pulse", 128'(bus.done), '0);
    set_rd(0, 7'd126);
    set_rd(1, 7'd127);
    set_rd(2, 7'd0);
    set_rd(3, 7'd1);
    set_rd(4, 7'd2);
    #1;
    check_val("t5_e126", rd(0), dv[0]);
    check_val("t5_e127", rd(1), dv[1]);
    check_val("t5_e0", rd(2), dv[2]);
    check_val("t5_e1", rd(3), dv[3]);
    check_val("t5_e2", rd(4), '0);

    // 6: reset in the middle of a load
    bus.ld_base  = 7'd10;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    beat(dv[0], 1'b0);
    beat(dv[1], 1'b0);
    set_rd(0, 7'd10);
    set_rd(1, 7'd126);
    #1;
    check_val("t6_pre", rd(0), dv[0]);
    rst = 1'b1;
    #1;
    check_val("t6_busy", 128'(bus.busy), '0);
    check_val("t6_ready", 128'(bus.ld_ready), '0);
    check_val("t6_e10", rd(0), '0);
    check_val("t6_e126", rd(1), '0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus.ld_base  = 7'd20;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    check_val("t6_reload_ready", 128'(bus.ld_ready), 128'd1);
    beat(dv[2], 1'b1);
    check_val("t6_reload_done", 128'(bus.done), 128'd1);
    set_rd(0, 7'd20);
    set_rd(1, 7'd11);
    #1;
    check_val("t6_e20", rd(0), dv[2]);
    check_val("t6_e11", rd(1), '0);

    // 7: clear wins over a simultaneous load start
    tick();
    bus.clr_req  = 1'b1;
    bus.ld_start = 1'b1;
    bus.ld_base  = 7'd0;
    tick();
    bus.clr_req  = 1'b0;
    bus.ld_start = 1'b0;
    check_val("t7_ready", 128'(bus.ld_ready), '0);
    check_val("t7_busy", 128'(bus.busy), 128'd1);
    for (int c = 0; c < 200; c++) begin
      if (!bus.busy) break;
      tick();
    end
    check_val("t7_wait", 128'(bus.busy), '0);
    set_rd(0, 7'd20);
    #1;
    check_val("t7_e20", rd(0), '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spu_regfile_mp.md
Name: spu_regfile_mp

Overview:
- Parametrised multi-port register file for the SPU datapath.
- Generalises the fixed 128x128, 2-write/6-read file to NUM_WR write ports, NUM_RD read ports and configurable DEPTH/WIDTH.
- Adds per-byte write enables, a sequential bulk-clear engine, and a valid/ready preload stream that replaces the reset-time preload hack.
- Sits between the decode/operand-fetch stage (reads) and the writeback stages (writes).

Parameters:
- WIDTH, 128, register width in bits; must be a multiple of 8.
- DEPTH, 128, number of registers.
- AW, $clog2(DEPTH), address width.
- NUM_WR, 2, write ports.
- NUM_RD, 6, read ports.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  flattened write addresses; port k occupies slice k
- wr_data  in  NUM_WR*WIDTH  flattened write data
- wr_be  in  NUM_WR*(WIDTH/8)  byte enables; bit j covers byte j, byte 0 = MSB byte, bits [0:7]
- rd_addr  in  NUM_RD*AW  flattened read addresses
- rd_data  out  NUM_RD*WIDTH  flattened read data
- clr_req  in  1  pulse; start bulk clear
- ld_start  in  1  pulse; start preload at ld_base
- ld_base  in  AW  first preload address
- ld_valid  in  1  preload beat valid
- ld_data  in  WIDTH  preload beat data
- ld_last  in  1  final preload beat
- ld_ready  out  1  preload beat accepted when ld_valid && ld_ready
- busy  out  1  clear or load in progress
- done  out  1  one-cycle pulse when clear or load completes

Behaviour:
- Reset (async): all entries 0; FSM to IDLE; busy=0, done=0, ld_ready=0; internal pointer 0. Reads during reset return 0.
- Bit ordering is big-endian ([0:WIDTH-1]), matching the rest of the SPU.
- Reads are combinational, with a bypass in IDLE only:
  - For each read port, merge same-cycle writes byte-wise.
  - A byte comes from the lowest-index write port with wr_en, a matching address and wr_be set for that byte.
  - Otherwise the byte comes from the array.
- Writes are synchronous at posedge:
  - Only bytes with be=1 update.
  - Same address on multiple ports: per byte, the lowest-index port wins.
  - wr_en with all-zero be is a no-op.
  - Out-of-range address (>= DEPTH, when DEPTH is not a power of 2): write ignored, read returns 0.
- FSM states: IDLE, CLEAR, LOAD.
- IDLE:
  - clr_req -> CLEAR with ptr=0.
  - else ld_start -> LOAD with ptr=ld_base.
  - clr_req has priority over ld_start when both arrive in the same cycle.
- CLEAR:
  - Each cycle entry[ptr] <= 0 and ptr++.
  - After entry DEPTH-1 is cleared: done=1 for one cycle, then IDLE.
  - Latency is exactly DEPTH cycles.
- LOAD:
  - ld_ready=1.
  - On each accepted beat: entry[ptr] <= ld_data (full width, no be), ptr wraps from DEPTH-1 to 0.
  - Accepted beat with ld_last=1 -> done pulse the next cycle, then IDLE.
  - ld_valid=0 stalls with no state change.
- While busy=1:
  - wr_en is ignored; writes are dropped, not queued.
  - Read bypass is disabled; reads return array contents.
  - A preload write is visible to reads the cycle after acceptance.
  - clr_req and ld_start are ignored.
- Reset mid-CLEAR or mid-LOAD: immediate abort, array zeroed, IDLE.
- busy is registered and equals (state != IDLE).

Decomposition:
- Package spu_rf_pkg holds:
  - state enum {IDLE, CLEAR, LOAD};
  - localparam BE_W = WIDTH/8;
  - a function that extracts slice k of a flattened vector.
- One sub-module, spu_rf_bypass: per-read-port combinational byte-wise merge of the write ports over the array data. It is instantiated NUM_RD times via generate.

Test Plan:
1. Reset, then read all 6 ports at addr 0,5,17,64,100,127 -> all rd_data=0, busy=0.
2. Forwarding and priority:
   - Setup: wr0 addr 10, data all-0xAA, be all-1; wr1 addr 10, data all-0x55, be all-1; rd0 addr 10 in the same cycle.
   - Required: rd0 = all 0xAA combinationally; next cycle entry 10 = all 0xAA.
3. Byte-wise merge:
   - Setup: entry 3 = 0; wr0 addr 3, data 0x11.., be=0xF000; wr1 addr 3, data 0x22.., be=0xFF00.
   - Required: entry 3 bytes 0-3 = 0x11, bytes 4-7 = 0x22, bytes 8-15 = 0x00.
4. Bulk clear:
   - Setup: fill entries; pulse clr_req; drive wr_en=1 during clear.
   - Required: busy=1 for exactly 128 cycles; done pulse on cycle 128; all entries 0; the writes are dropped.
5. Preload with wrap and stalls:
   - Setup: ld_start with ld_base=126; 4 beats D0-D3 with ld_valid gaps; ld_last on D3.
   - Required: entries 126,127,0,1 = D0-D3; done pulse once; busy falls the following cycle.
6. Reset mid-LOAD:
   - Setup: assert rst after 2 beats.
   - Required: all entries 0, busy=0, ld_ready=0 immediately; a later ld_start works normally.
